// File: rtl/mod_type_sched.sv
// Glitch-free scheduler for the ISO14443-A modulation-type select shared by ARM and relay engine.
// Optional build macro MOD_SCHED_TIMEOUT_EN adds a safe-point timeout and the sticky switch_err flag.
module mod_type_sched #(
    parameter int unsigned GUARD_CYCLES   = 16,
    parameter int unsigned HOLD_CYCLES    = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       ck_1356meg,
    input  logic       reset,
    input  logic       arm_req,
    input  logic [2:0] arm_mod_type,
    output logic       arm_ack,
    input  logic       relay_req,
    input  logic [2:0] relay_mod_type,
    output logic       relay_ack,
    input  logic       relay_active,
    input  logic       mod_idle,
    output logic [2:0] mod_type,
    output logic       owner,
    output logic       busy,
    output logic       switch_err
);
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {IDLE, WAIT_SAFE, GUARD, APPLY, HOLD} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    lat_type, lat_type_d, mod_type_d;
    logic          owner_d, same_pend, same_pend_d;
    logic          arm_ack_d, relay_ack_d, busy_d;
    logic          arm_el, relay_el, pick_relay;
    logic [2:0]    pick_type;
    logic          grant_c, drop_c, timeout_hit;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == '1) ? x : x + CW'(1);
    endfunction

    function automatic logic reached(input logic [CW-1:0] x, input int unsigned lim);
        return (32'(x) + 32'd1) >= lim;
    endfunction

    // Requests are masked while an ack is outstanding so a held req is not regranted.
    assign arm_el     = arm_req && !arm_ack && !relay_ack && !same_pend;
    assign relay_el   = relay_req && relay_active && !arm_ack && !relay_ack && !same_pend;
    assign pick_relay = relay_el;
    assign pick_type  = pick_relay ? relay_mod_type : arm_mod_type;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lat_type_d  = lat_type;
        mod_type_d  = mod_type;
        owner_d     = owner;
        same_pend_d = 1'b0;
        arm_ack_d   = 1'b0;
        relay_ack_d = 1'b0;
        grant_c     = 1'b0;
        drop_c      = 1'b0;
        case (state)
            IDLE: begin
                if (same_pend) begin
                    arm_ack_d   = !owner;
                    relay_ack_d = owner;
                end else if (arm_el || relay_el) begin
                    grant_c    = 1'b1;
                    owner_d    = pick_relay;
                    lat_type_d = pick_type;
                    // A request for the mode already driven completes without guard or hold.
                    if (pick_type == mod_type) same_pend_d = 1'b1;
                    else                       state_d     = WAIT_SAFE;
                end
            end
            WAIT_SAFE: begin
                if (timeout_hit) begin
                    drop_c = 1'b1;
                end else if (mod_idle) begin
                    cnt_d   = '0;
                    state_d = GUARD;
                end
            end
            GUARD: begin
                if (timeout_hit) begin
                    drop_c = 1'b1;
                end else if (!mod_idle) begin
                    cnt_d   = '0;
                    state_d = WAIT_SAFE;
                end else begin
                    cnt_d = sat_inc(cnt);
                    if (reached(cnt, GUARD_CYCLES)) state_d = APPLY;
                end
            end
            APPLY: begin
                mod_type_d  = lat_type;
                arm_ack_d   = !owner;
                relay_ack_d = owner;
                cnt_d       = '0;
                state_d     = HOLD;
            end
            HOLD: begin
                cnt_d = sat_inc(cnt);
                if (reached(cnt, HOLD_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Timed-out request: ack without switching, straight back to IDLE.
        if (drop_c) begin
            arm_ack_d   = !owner;
            relay_ack_d = owner;
            cnt_d       = '0;
            state_d     = IDLE;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_type  <= '0;
            mod_type  <= '0;
            owner     <= 1'b0;
            same_pend <= 1'b0;
            arm_ack   <= 1'b0;
            relay_ack <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            lat_type  <= lat_type_d;
            mod_type  <= mod_type_d;
            owner     <= owner_d;
            same_pend <= same_pend_d;
            arm_ack   <= arm_ack_d;
            relay_ack <= relay_ack_d;
            busy      <= busy_d;
        end
    end

`ifdef MOD_SCHED_TIMEOUT_EN
    logic [CW-1:0] tmo, tmo_d;

    // Timeout runs from the grant through WAIT_SAFE and GUARD.
    always_comb begin
        tmo_d = tmo;
        if (grant_c)                                tmo_d = '0;
        else if (state == WAIT_SAFE || state == GUARD) tmo_d = sat_inc(tmo);
    end

    assign timeout_hit = reached(tmo, TIMEOUT_CYCLES);

    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            tmo        <= '0;
            switch_err <= 1'b0;
        end else begin
            tmo        <= tmo_d;
            switch_err <= switch_err | drop_c;
        end
    end
`else
    assign timeout_hit = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
    assign switch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mod_type_sched.sv
// Directed, table-driven bench for mod_type_sched (GUARD=16, HOLD=64, TIMEOUT=100).
module tb_mod_type_sched;
    localparam int unsigned G = 16;
    localparam int unsigned H = 64;
    localparam int unsigned T = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arm_req = 1'b0, relay_req = 1'b0, relay_active = 1'b0, mod_idle = 1'b1;
    logic [2:0] arm_mod_type = '0, relay_mod_type = '0;
    logic       arm_ack, relay_ack, owner, busy, switch_err;
    logic [2:0] mod_type;

    int nvec = 0;
    int nerr = 0;
    int overlap = 0;

    mod_type_sched #(.GUARD_CYCLES(G), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
        .ck_1356meg(clk), .reset(reset),
        .arm_req(arm_req), .arm_mod_type(arm_mod_type), .arm_ack(arm_ack),
        .relay_req(relay_req), .relay_mod_type(relay_mod_type), .relay_ack(relay_ack),
        .relay_active(relay_active), .mod_idle(mod_idle),
        .mod_type(mod_type), .owner(owner), .busy(busy), .switch_err(switch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (arm_ack && relay_ack) overlap++;
    end

    typedef struct {
        bit         a_req;
        bit         r_req;
        bit         r_act;
        logic [2:0] a_t;
        logic [2:0] r_t;
        bit         exp_relay;
        logic [2:0] exp_type;
        int         exp_lat;
        logic [2:0] sec_type;
        int         sec_lat;
    } vec_t;

    vec_t vec [8];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // k = index of the edge just passed, 0 being the first edge after the call.
    task automatic wait_ack(input int budget, output int k, output bit got_relay,
                            output bit busy_seen, output bit timed_out);
        k = -1; got_relay = 0; busy_seen = 0; timed_out = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            k++;
            if (busy) busy_seen = 1;
            if (arm_ack || relay_ack) begin
                got_relay = relay_ack;
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        @(negedge clk);
    endtask

    initial begin
        int  k;
        bit  r, bs, to;

        // 82 = HOLD + 1 + GUARD + 2 - 1: measured from the edge after the first ack.
        vec[0] = '{1, 0, 0, 3'b100, 3'b000, 0, 3'b100, 18, 3'b000, 0};
        vec[1] = '{1, 1, 1, 3'b010, 3'b101, 1, 3'b101, 18, 3'b010, 82};
        vec[2] = '{1, 1, 0, 3'b011, 3'b110, 0, 3'b011, 18, 3'b000, 0};
        vec[3] = '{0, 1, 1, 3'b000, 3'b111, 1, 3'b111, 18, 3'b000, 0};
        vec[4] = '{1, 0, 0, 3'b111, 3'b000, 0, 3'b111, 1,  3'b000, 0};
        vec[5] = '{0, 1, 1, 3'b000, 3'b111, 1, 3'b111, 1,  3'b000, 0};
        vec[6] = '{1, 0, 0, 3'b000, 3'b000, 0, 3'b000, 18, 3'b000, 0};
        vec[7] = '{1, 0, 0, 3'b000, 3'b000, 0, 3'b000, 1,  3'b000, 0};

        repeat (2) @(negedge clk);
        check("reset mod_type", int'(mod_type), 0);
        check("reset acks", int'({arm_ack, relay_ack}), 0);
        check("reset busy/owner/err", int'({busy, owner, switch_err}), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            arm_mod_type   = vec[v].a_t;
            relay_mod_type = vec[v].r_t;
            relay_active   = vec[v].r_act;
            arm_req        = vec[v].a_req;
            relay_req      = vec[v].r_req;
            wait_ack(300, k, r, bs, to);
            check($sformatf("v%0d ack seen", v), int'(to), 0);
            check($sformatf("v%0d winner", v), int'(r), int'(vec[v].exp_relay));
            check($sformatf("v%0d latency", v), k, vec[v].exp_lat);
            check($sformatf("v%0d mod_type", v), int'(mod_type), int'(vec[v].exp_type));
            check($sformatf("v%0d owner", v), int'(owner), int'(vec[v].exp_relay));
            if (vec[v].exp_lat == 1) check($sformatf("v%0d busy", v), int'(bs), 0);
            if (r) relay_req = 1'b0; else arm_req = 1'b0;
            if (vec[v].sec_lat != 0) begin
                wait_ack(300, k, r, bs, to);
                check($sformatf("v%0d second ack seen", v), int'(to), 0);
                check($sformatf("v%0d second winner", v), int'(r), int'(!vec[v].exp_relay));
                check($sformatf("v%0d second latency", v), k, vec[v].sec_lat);
                check($sformatf("v%0d second mod_type", v), int'(mod_type), int'(vec[v].sec_type));
            end
            arm_req = 1'b0;
            relay_req = 1'b0;
            wait_idle();
        end

        // Guard interrupted at count 10 for 5 cycles.
        relay_active = 1'b0;
        arm_mod_type = 3'b001;
        arm_req = 1'b1;
        k = -1; to = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (arm_ack || relay_ack) begin to = 0; break; end
            if (k == 11) mod_idle = 1'b0;
            if (k == 16) mod_idle = 1'b1;
        end
        check("guard restart ack seen", int'(to), 0);
        check("guard restart latency", k, 34);
        check("guard restart mod_type", int'(mod_type), 1);
        arm_req = 1'b0;
        wait_idle();

        // Reset during GUARD, request held across release.
        arm_mod_type = 3'b110;
        arm_req = 1'b1;
        wait_ack(9, k, r, bs, to);
        check("pre-reset no ack", int'(to), 1);
        reset = 1'b1;
        #1;
        check("mid reset mod_type", int'(mod_type), 0);
        check("mid reset acks/busy", int'({arm_ack, relay_ack, busy}), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_ack(100, k, r, bs, to);
        check("post-reset busy", int'(bs), 1);
        check("post-reset latency", k, 18);
        check("post-reset mod_type", int'(mod_type), 6);
        arm_req = 1'b0;
        wait_idle();

        mod_idle = 1'b0;
        arm_mod_type = 3'b101;
        arm_req = 1'b1;
`ifdef MOD_SCHED_TIMEOUT_EN
        wait_ack(300, k, r, bs, to);
        check("timeout latency", k, 100);
        check("timeout mod_type", int'(mod_type), 6);
        check("timeout err", int'(switch_err), 1);
        arm_req = 1'b0;
        repeat (5) @(negedge clk);
        check("err sticky", int'(switch_err), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("err cleared by reset", int'(switch_err), 0);
`else
        wait_ack(150, k, r, bs, to);
        check("no timeout wait", int'(to), 1);
        check("err tied low", int'(switch_err), 0);
        mod_idle = 1'b1;
        wait_ack(100, k, r, bs, to);
        check("late safe point latency", k, 17);
        check("late safe point mod_type", int'(mod_type), 5);
        arm_req = 1'b0;
`endif
        mod_idle = 1'b1;
        wait_idle();

        check("ack overlap count", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
